rib_rr_arbiter: RTL and testbench



---
 rtl/rib_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_rib_rr_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one RIB slave port among NUM_M masters.
// One transfer at a time: IDLE picks a winner, BUSY drives the slave until ack
// or timeout, DONE returns a one-cycle completion pulse to the winner.
module rib_rr_arbiter #(
    parameter int NUM_M   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M-1:0]    m_req_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_wdata_i,
    output logic [NUM_M-1:0]    m_done_o,
    output logic [DW-1:0]       m_rdata_o,
    output logic                m_err_o,
    output logic [NUM_M-1:0]    m_hold_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW-1:0]       s_wdata_o,
    input  logic [DW-1:0]       s_rdata_i,
    input  logic                s_ack_i
);

    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   cand;
    logic            sel_vld;
    logic [CW-1:0]   cnt;
    logic            timeout_hit;
    logic            lat_we;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [DW-1:0]   rdata;
    logic            err;
    logic [AW-1:0]   addr_arr  [NUM_M];
    logic [DW-1:0]   wdata_arr [NUM_M];

    // Unpack the flat per-master address and write-data buses
    always_comb begin
        for (int k = 0; k < NUM_M; k++) begin
            addr_arr[k]  = m_addr_i[k*AW +: AW];
            wdata_arr[k] = m_wdata_i[k*DW +: DW];
        end
    end

    // Rotating-priority search: first requester at or above ptr, wrapping
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_M; i++) begin
            cand = PW'((int'(ptr) + i) % NUM_M);
            if (!sel_vld && m_req_i[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
        end
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an ack outside BUSY never changes the state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sel_vld) state_next = BUSY;
            BUSY:    if (s_ack_i || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transfer datapath: latch the winner's command, count, capture the result
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            win       <= '0;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        win       <= sel;
                        lat_we    <= m_we_i[sel];
                        lat_addr  <= addr_arr[sel];
                        lat_wdata <= wdata_arr[sel];
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    // ack takes precedence over a simultaneous timeout
                    if (s_ack_i) begin
                        rdata <= lat_we ? '0 : s_rdata_i;
                        err   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                end
                DONE: begin
                    ptr <= (win == PW'(NUM_M - 1)) ? '0 : win + PW'(1);
                end
                default: ;
            endcase
        end
    end

    // One-hot completion pulse to the winner while in DONE
    always_comb begin
        m_done_o = '0;
        if (state == DONE) begin
            m_done_o[win] = 1'b1;
        end
    end

    assign s_req_o   = (state == BUSY);
    assign s_we_o    = lat_we;
    assign s_addr_o  = lat_addr;
    assign s_wdata_o = lat_wdata;
    assign m_rdata_o = rdata;
    assign m_err_o   = err;
    assign m_hold_o  = m_req_i & ~m_done_o;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Self-checking bench for rib_rr_arbiter: directed scenarios followed by a
// randomized phase, all checked against a priority-queue reference model.
module tb_rib_rr_arbiter;

    localparam int NUM_M   = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_M-1:0]    req;
    logic [NUM_M-1:0]    we;
    logic [AW-1:0]       addr  [NUM_M];
    logic [DW-1:0]       wdata [NUM_M];
    logic [NUM_M*AW-1:0] m_addr_i;
    logic [NUM_M*DW-1:0] m_wdata_i;
    logic [NUM_M-1:0]    m_done_o;
    logic [DW-1:0]       m_rdata_o;
    logic                m_err_o;
    logic [NUM_M-1:0]    m_hold_o;
    logic                s_req_o;
    logic                s_we_o;
    logic [AW-1:0]       s_addr_o;
    logic [DW-1:0]       s_wdata_o;
    logic [DW-1:0]       s_rdata_i;
    logic                s_ack_i;

    int checks = 0;
    int errors = 0;
    int prio[$];
    int waits [NUM_M];
    int rr_order [6] = '{0, 1, 3, 0, 1, 3};

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NUM_M; k++) begin
            m_addr_i[k*AW +: AW]  = addr[k];
            m_wdata_i[k*DW +: DW] = wdata[k];
        end
    end

    rib_rr_arbiter #(
        .NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req_i(req), .m_we_i(we), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_done_o(m_done_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .m_hold_o(m_hold_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bit_at(input logic [NUM_M-1:0] v, input int k);
        logic [NUM_M-1:0] t;
        t = v >> k;
        return t[0];
    endfunction

    function automatic int onehot_idx(input logic [NUM_M-1:0] v);
        for (int k = 0; k < NUM_M; k++) if (bit_at(v, k)) return k;
        return -1;
    endfunction

    // Model: priority queue of master indices, highest priority first
    function automatic void model_reset();
        prio.delete();
        for (int k = 0; k < NUM_M; k++) prio.push_back(k);
    endfunction

    function automatic int model_pick();
        foreach (prio[i]) if (bit_at(req, prio[i])) return prio[i];
        return -1;
    endfunction

    // Winner moves to the back of the queue
    function automatic void model_grant(input int w);
        while (prio[0] != w) prio.push_back(prio.pop_front());
        prio.push_back(prio.pop_front());
    endfunction

    // One transfer starting in IDLE with requests presented; ack_at is the
    // BUSY cycle (1-based) that gets the ack, 0 for none. Returns in IDLE.
    task automatic xfer(input int ack_at, input logic [DW-1:0] rd, input bit drop,
                        input bit scramble, output int got_w);
        int               w;
        int               n;
        bit               acked;
        logic [AW-1:0]    e_addr;
        logic [DW-1:0]    e_wdata;
        logic             e_we;
        logic [NUM_M-1:0] oh;
        w = model_pick();
        if (w < 0) begin
            chk("xfer_has_request", 64'(req), 64'(1));
            got_w = -1;
            return;
        end
        e_addr  = addr[w];
        e_wdata = wdata[w];
        e_we    = bit_at(we, w);
        oh      = NUM_M'(1) << w;
        n       = 0;
        acked   = 1'b0;
        step();
        forever begin
            n++;
            chk("busy_s_req", 64'(s_req_o), 64'(1));
            chk("busy_s_addr", 64'(s_addr_o), 64'(e_addr));
            chk("busy_s_we", 64'(s_we_o), 64'(e_we));
            chk("busy_s_wdata", 64'(s_wdata_o), 64'(e_wdata));
            chk("busy_hold", 64'(m_hold_o), 64'(req));
            chk("busy_no_done", 64'(m_done_o), 64'(0));
            if (scramble) begin
                for (int k = 0; k < NUM_M; k++) begin
                    addr[k]  = $urandom;
                    wdata[k] = $urandom;
                end
                we = NUM_M'($urandom);
            end
            if (n == ack_at) begin
                s_ack_i   = 1'b1;
                s_rdata_i = rd;
                acked     = 1'b1;
            end
            step();
            s_ack_i   = 1'b0;
            s_rdata_i = $urandom;
            if (acked || n == TIMEOUT) break;
        end
        chk("done_s_req", 64'(s_req_o), 64'(0));
        chk("done_onehot", 64'(m_done_o), 64'(oh));
        chk("done_rdata", 64'(m_rdata_o), 64'((acked && !e_we) ? rd : '0));
        chk("done_err", 64'(m_err_o), 64'(!acked));
        chk("done_hold", 64'(m_hold_o), 64'(req & ~oh));
        got_w = onehot_idx(m_done_o);
        model_grant(w);
        if (drop) req = req & ~oh;
        step();
        chk("idle_no_done", 64'(m_done_o), 64'(0));
        chk("idle_s_req", 64'(s_req_o), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int a;
        int mx;
        rst       = 1'b1;
        req       = '0;
        we        = '0;
        s_ack_i   = 1'b0;
        s_rdata_i = '0;
        for (int k = 0; k < NUM_M; k++) begin
            addr[k]  = '0;
            wdata[k] = '0;
            waits[k] = 0;
        end
        model_reset();
        step();
        step();
        chk("rst_s_req", 64'(s_req_o), 64'(0));
        chk("rst_s_we", 64'(s_we_o), 64'(0));
        chk("rst_s_addr", 64'(s_addr_o), 64'(0));
        chk("rst_s_wdata", 64'(s_wdata_o), 64'(0));
        chk("rst_done", 64'(m_done_o), 64'(0));
        chk("rst_rdata", 64'(m_rdata_o), 64'(0));
        chk("rst_err", 64'(m_err_o), 64'(0));
        rst = 1'b0;

        // Single read by master 2, ack on 2nd BUSY cycle
        addr[2] = 32'h1000_0004;
        we      = '0;
        req     = 4'b0100;
        xfer(2, 32'hDEAD_BEEF, 1'b1, 1'b0, w);
        chk("read_winner", 64'(w), 64'(2));
        // ptr now 3: with everyone requesting, master 3 goes first
        req = 4'b1111;
        xfer(1, 32'h0000_0033, 1'b1, 1'b0, w);
        chk("ptr_after_read", 64'(w), 64'(3));
        req = '0;
        step();

        // Round-robin among masters 0,1,3 from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            xfer(1, DW'(32'h100 + i), 1'b0, 1'b0, w);
            chk("rr_order", 64'(w), 64'(rr_order[i]));
        end
        req = '0;
        step();

        // Write by master 1 with inputs scrambled during BUSY
        addr[1]  = 32'h0000_0020;
        wdata[1] = 32'h55AA_1234;
        we       = 4'b0010;
        req      = 4'b0010;
        xfer(3, 32'hFFFF_FFFF, 1'b1, 1'b1, w);
        chk("write_winner", 64'(w), 64'(1));

        // Timeout, then a normal transfer for the next requester
        we  = '0;
        req = 4'b0001;
        xfer(0, 32'h0, 1'b1, 1'b0, w);
        chk("timeout_winner", 64'(w), 64'(0));
        req = 4'b1000;
        xfer(1, 32'hCAFE_F00D, 1'b1, 1'b0, w);
        chk("after_timeout_winner", 64'(w), 64'(3));

        // Ack on the final (timeout) cycle wins
        we  = '0;
        req = 4'b0010;
        xfer(TIMEOUT, 32'h0000_0001, 1'b1, 1'b0, w);

        // Ack while IDLE with no requests is ignored
        s_ack_i   = 1'b1;
        s_rdata_i = 32'h1234_5678;
        step();
        s_ack_i = 1'b0;
        chk("idle_ack_s_req", 64'(s_req_o), 64'(0));
        chk("idle_ack_done", 64'(m_done_o), 64'(0));
        step();
        chk("idle_ack_done2", 64'(m_done_o), 64'(0));
        chk("idle_ack_rdata", 64'(m_rdata_o), 64'(1));

        // Reset on the 3rd BUSY cycle abandons the transfer
        addr[0] = 32'hABCD_0000;
        wdata[0] = 32'h0BAD_0BAD;
        we      = 4'b0001;
        req     = 4'b0001;
        step();
        step();
        step();
        chk("midbusy_s_req", 64'(s_req_o), 64'(1));
        rst = 1'b1;
        step();
        chk("midrst_s_req", 64'(s_req_o), 64'(0));
        chk("midrst_done", 64'(m_done_o), 64'(0));
        chk("midrst_s_we", 64'(s_we_o), 64'(0));
        chk("midrst_s_addr", 64'(s_addr_o), 64'(0));
        chk("midrst_s_wdata", 64'(s_wdata_o), 64'(0));
        chk("midrst_rdata", 64'(m_rdata_o), 64'(0));
        chk("midrst_err", 64'(m_err_o), 64'(0));
        rst = 1'b0;
        model_reset();
        we  = '0;
        req = 4'b1111;
        xfer(2, 32'h7777_0000, 1'b1, 1'b0, w);
        chk("post_rst_winner", 64'(w), 64'(0));

        // Randomized traffic with fairness tracking
        for (int k = 0; k < NUM_M; k++) waits[k] = 0;
        for (int it = 0; it < 40; it++) begin
            if (req == '0) req = NUM_M'($urandom_range(1, (1 << NUM_M) - 1));
            else if ($urandom_range(0, 1) == 1) req = req | NUM_M'($urandom);
            for (int k = 0; k < NUM_M; k++) begin
                addr[k]  = $urandom;
                wdata[k] = $urandom;
                if (!bit_at(req, k)) waits[k] = 0;
            end
            we = NUM_M'($urandom);
            a  = $urandom_range(1, TIMEOUT + 4);
            if (a > TIMEOUT) a = 0;
            xfer(a, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
            mx = 0;
            for (int k = 0; k < NUM_M; k++) begin
                if (k == w) waits[k] = 0;
                else if (bit_at(req, k)) waits[k]++;
                if (waits[k] > mx) mx = waits[k];
            end
            chk("fairness", 64'(mx <= NUM_M - 1), 64'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
